apb_uart_regs: RTL and testbench
================================

APB_UART_REGS -- requirements
Module: apb_uart_regs

Interface
REQ-001 SHALL have parameter DBIT, default 8: UART data width in bits.
REQ-002 SHALL have parameter RX_DEPTH, default 4: receive FIFO depth, a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have APB ports:
  - psel, penable, pwrite: inputs, 1 bit each.
  - paddr: input, 4 bits.
  - pwdata: input, 32 bits.
  - prdata: output, 32 bits.
  - pready, pslverr: outputs, 1 bit each.
REQ-006 SHALL have UART-side ports:
  - din: output, DBIT bits.
  - dvsr: output, 11 bits.
  - tx_start: output, 1 bit.
  - tx_busy, tx_done_tick, rx_done_tick: inputs, 1 bit each.
  - dout: input, DBIT bits.
REQ-007 SHALL have port irq, output, 1 bit, present only when UART_APB_IRQ_EN is defined.

Function
REQ-008 SHALL implement the APB FSM with states IDLE, SETUP and ACCESS:
  - IDLE to SETUP on psel && !penable.
  - SETUP to ACCESS on psel && penable.
  - ACCESS to SETUP on a back-to-back psel && !penable; otherwise ACCESS to IDLE.
REQ-009 SHALL assert pready = psel && penable, giving zero wait states; transfer completes in ACCESS.
REQ-010 SHALL decode the register map on paddr[3:2]:
  - 0 TXDATA: write-only.
  - 1 RXDATA: read-only.
  - 2 STATUS: read, with write-1-to-clear.
  - 3 DVSR: read/write, bits 10:0.
REQ-011 SHALL drive prdata = 0 when not in an access cycle or on a write, and zero-extend all unused bits.
REQ-012 On a TXDATA write with the hold register empty, SHALL load pwdata[DBIT-1:0] into the hold register and set hold_valid.
REQ-013 On a TXDATA write with hold_valid = 1, SHALL assert pslverr, drop the data and leave the hold register unchanged.
REQ-014 SHALL implement the TX FSM with states T_IDLE, T_START and T_WAIT:
  - T_IDLE to T_START when hold_valid && !tx_busy.
  - In T_START, assert tx_start for exactly one cycle with din = hold data, clear hold_valid, then go to T_WAIT.
  - T_WAIT to T_IDLE on tx_done_tick.
REQ-015 din SHALL hold its last launched value between transmissions.
REQ-016 On an RXDATA read, SHALL return the FIFO head in prdata[DBIT-1:0] and pop it at the end of the access cycle.
REQ-017 An RXDATA read of an empty FIFO SHALL return 0, assert pslverr and not pop.
REQ-018 On rx_done_tick, SHALL push dout into the FIFO.
REQ-019 rx_done_tick with the FIFO full and no pop in the same cycle SHALL drop the byte and set the sticky overrun bit.
REQ-020 rx_done_tick on a full FIFO coinciding with a pop SHALL push and pop in the same cycle, keep the count unchanged, and not set overrun.
REQ-021 FIFO pointers SHALL be log2(RX_DEPTH) bits wide and wrap modulo RX_DEPTH; the count SHALL be log2(RX_DEPTH)+1 bits.
REQ-022 STATUS read SHALL return:
  - bit0: tx_busy | hold_valid | (TX state != T_IDLE).
  - bit1: rx_empty.
  - bit2: rx_full.
  - bit3: overrun.
  - bit4: hold_valid.
  - bits 31:5: 0.
REQ-023 A STATUS write with pwdata[3] = 1 SHALL clear overrun; a simultaneous overrun set SHALL take priority over the clear.
REQ-024 A DVSR write SHALL update dvsr from the cycle after the access.
REQ-025 pslverr SHALL be asserted only during psel && penable, and only for the cases in REQ-013 and REQ-017.

Reset
REQ-026 While rst = 1, SHALL hold: APB FSM in IDLE, TX FSM in T_IDLE, hold_valid = 0, FIFO empty, overrun = 0.
REQ-027 While rst = 1, SHALL hold outputs: tx_start = 0, din = 0, dvsr = 11'd162, prdata = 0, pslverr = 0, irq = 0.
REQ-028 Reset asserted mid-transmission SHALL abandon the T_WAIT state; any tx_done_tick after reset release SHALL be ignored while in T_IDLE.

Configuration
REQ-029 With UART_APB_IRQ_EN defined, SHALL add STATUS bit5 irq_en, read/write, reset 0.
REQ-030 With UART_APB_IRQ_EN defined, SHALL register irq = irq_en && (!rx_empty || overrun); irq asserts one cycle after the condition becomes true.
REQ-031 Without UART_APB_IRQ_EN, SHALL omit the irq port and read STATUS bit5 as 0.

Verification
REQ-032 After reset, read DVSR, then write DVSR = 0x145 and read back -> first read 162; dvsr port = 0x145 from the cycle after the write; readback 0x145.
REQ-033 Write TXDATA = 0xA5 with tx_busy = 0 -> exactly one tx_start pulse with din = 0xA5.
REQ-034 Write TXDATA twice while tx_busy = 1 -> second write pslverr = 1; 0xA5 is launched only after tx_busy falls.
REQ-035 Push 0x11, 0x22, 0x33, 0x44, 0x55 via rx_done_tick with no reads, then read RXDATA 5 times:
  - Reads return 0x11, 0x22, 0x33, 0x44.
  - Fifth read returns 0 with pslverr = 1.
  - STATUS bit3 = 1; writing STATUS = 0x8 clears it.
REQ-036 With the FIFO full, apply rx_done_tick in the same cycle as an RXDATA read -> no overrun and count stays 4.
REQ-037 Assert rst during T_WAIT, then drive tx_done_tick -> TX FSM stays in T_IDLE, tx_start = 0 and STATUS = 0x2.

Source files
------------

// File: rtl/apb_uart_regs.sv
// rtl/apb_uart_regs.sv - APB register front end for a UART: TX hold register, RX FIFO, status and divisor
// Optional feature macro: UART_APB_IRQ_EN (irq output plus STATUS.irq_en)
module apb_uart_regs #(
    parameter int DBIT     = 8,
    parameter int RX_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            psel,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [3:0]      paddr,
    input  logic [31:0]     pwdata,
    output logic [31:0]     prdata,
    output logic            pready,
    output logic            pslverr,
    output logic [DBIT-1:0] din,
    output logic [10:0]     dvsr,
    output logic            tx_start,
    input  logic            tx_busy,
    input  logic            tx_done_tick,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] dout
`ifdef UART_APB_IRQ_EN
    ,
    output logic            irq
`endif
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT} tx_state_t;

    apb_state_t apb_state, apb_next;
    tx_state_t  tx_state, tx_next;

    logic            access_en;
    logic            wr_txdata, rd_rxdata, wr_status, wr_dvsr;
    logic            hold_valid;
    logic [DBIT-1:0] hold_data;
    logic            tx_launch;
    logic            tx_active;
    logic            overrun;
    logic            irq_en_bit;

    logic [DBIT-1:0] rx_mem [RX_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   rx_count;
    logic            rx_empty, rx_full;
    logic            rx_push, rx_pop, rx_overflow;
    logic [31:0]     status_word;
    logic            unused_bits;

    // ---------------- APB FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            apb_state <= IDLE;
        end else begin
            apb_state <= apb_next;
        end
    end

    always_comb begin
        apb_next = apb_state;
        case (apb_state)
            IDLE: begin
                if (psel && !penable) apb_next = SETUP;
            end
            SETUP: begin
                if (psel && penable) apb_next = ACCESS;
                else if (!psel)      apb_next = IDLE;
            end
            ACCESS: begin
                if (psel && !penable) apb_next = SETUP;
                else                  apb_next = IDLE;
            end
            default: apb_next = IDLE;
        endcase
    end

    // The access phase is the cycle whose closing edge moves SETUP into ACCESS.
    always_comb begin
        access_en = !rst && (apb_state == SETUP) && psel && penable;
        pready    = psel && penable;
    end

    assign wr_txdata = access_en &&  pwrite && (paddr[3:2] == 2'd0);
    assign rd_rxdata = access_en && !pwrite && (paddr[3:2] == 2'd1);
    assign wr_status = access_en &&  pwrite && (paddr[3:2] == 2'd2);
    assign wr_dvsr   = access_en &&  pwrite && (paddr[3:2] == 2'd3);

    assign pslverr = (wr_txdata && hold_valid) || (rd_rxdata && rx_empty);

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE: begin
                if (hold_valid && !tx_busy) tx_next = T_START;
            end
            T_START: tx_next = T_WAIT;
            T_WAIT: begin
                if (tx_done_tick) tx_next = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        tx_start  = !rst && (tx_state == T_START);
        tx_launch = (tx_state == T_IDLE) && hold_valid && !tx_busy;
        tx_active = tx_busy || hold_valid || (tx_state != T_IDLE);
    end

    // din is loaded on the launch edge so it is valid for the whole tx_start cycle and then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            din        <= '0;
            dvsr       <= 11'd162;
        end else begin
            if (tx_launch) din <= hold_data;
            if (tx_state == T_START) begin
                hold_valid <= 1'b0;
            end else if (wr_txdata && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= pwdata[DBIT-1:0];
            end
            if (wr_dvsr) dvsr <= pwdata[10:0];
        end
    end

    // ---------------- RX FIFO ----------------
    assign rx_empty    = (rx_count == '0);
    assign rx_full     = (rx_count == CW'(RX_DEPTH));
    assign rx_pop      = rd_rxdata && !rx_empty;
    assign rx_push     = rx_done_tick && (!rx_full || rx_pop);
    assign rx_overflow = rx_done_tick && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[wr_ptr] <= dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) wr_ptr <= wr_ptr + 1'b1;
            if (rx_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // A drop on a full FIFO outranks a simultaneous software clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (rx_overflow) begin
            overrun <= 1'b1;
        end else if (wr_status && pwdata[3]) begin
            overrun <= 1'b0;
        end
    end

    // ---------------- optional interrupt ----------------
`ifdef UART_APB_IRQ_EN
    logic irq_en;
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_status) irq_en <= pwdata[5];
            irq_q <= irq_en && (!rx_empty || overrun);
        end
    end

    assign irq        = irq_q && !rst;
    assign irq_en_bit = irq_en;
`else
    assign irq_en_bit = 1'b0;
`endif

    // ---------------- read mux ----------------
    assign status_word = {26'd0, irq_en_bit, hold_valid, overrun, rx_full, rx_empty, tx_active};

    always_comb begin
        prdata = '0;
        if (access_en && !pwrite) begin
            case (paddr[3:2])
                2'd1: begin
                    if (!rx_empty) prdata = 32'(rx_mem[rd_ptr]);
                end
                2'd2:    prdata = status_word;
                2'd3:    prdata = 32'(dvsr);
                default: prdata = '0;
            endcase
        end
    end

    assign unused_bits = ^{pwdata, paddr[1:0]};

endmodule

// File: tb/tb_apb_uart_regs.sv
// tb/tb_apb_uart_regs.sv - self-checking bench for apb_uart_regs with a queue-based reference model
module tb_apb_uart_regs;

    localparam logic [3:0] A_TX = 4'h0;
    localparam logic [3:0] A_RX = 4'h4;
    localparam logic [3:0] A_ST = 4'h8;
    localparam logic [3:0] A_DV = 4'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [7:0]  din;
    logic [10:0] dvsr;
    logic        tx_start, tx_busy, tx_done_tick, rx_done_tick;
    logic [7:0]  dout;
`ifdef UART_APB_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0]  launches[$];
    logic        last_ready;
    logic [10:0] last_dvsr;

    always #5 clk = ~clk;

    apb_uart_regs #(.DBIT(8), .RX_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .din(din), .dvsr(dvsr), .tx_start(tx_start), .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick), .rx_done_tick(rx_done_tick), .dout(dout)
`ifdef UART_APB_IRQ_EN
        , .irq(irq)
`endif
    );

    always @(negedge clk) begin
        if (tx_start === 1'b1) launches.push_back(din);
    end

    task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                       input logic with_rx, input logic [7:0] rxb,
                       output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        if (with_rx) begin
            rx_done_tick = 1'b1;
            dout = rxb;
        end
        @(negedge clk);
        rd = prdata; err = pslverr; last_ready = pready; last_dvsr = dvsr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; rx_done_tick = 1'b0;
    endtask

    task automatic apb_wr(input logic [3:0] a, input logic [31:0] wd, output logic err);
        logic [31:0] rd;
        apb(1'b1, a, wd, 1'b0, 8'h00, rd, err);
    endtask

    task automatic apb_rd(input logic [3:0] a, output logic [31:0] rd, output logic err);
        apb(1'b0, a, 32'h0, 1'b0, 8'h00, rd, err);
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done_tick = 1'b1; dout = b;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        tx_done_tick = 1'b1;
        @(posedge clk); #1;
        tx_done_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic err;
        rst = 1'b1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = A_RX;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        total++; if (din !== 8'h00) begin bad++; $display("FAIL reset_din got %h want 00", din); end
        total++; if (dvsr !== 11'd162) begin bad++; $display("FAIL reset_dvsr got %0d want 162", dvsr); end
        total++; if (prdata !== 32'h0) begin bad++; $display("FAIL reset_prdata got %h want 0", prdata); end
        total++; if (pslverr !== 1'b0) begin bad++; $display("FAIL reset_pslverr got %b want 0", pslverr); end
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        apb_rd(A_ST, rd, err);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL reset_status got %h want 2", rd); end
        apb_rd(A_RX, rd, err);
        total++; if (rd !== 32'h0 || err !== 1'b1) begin bad++; $display("FAIL empty_rx_read got %h/%b want 0/1", rd, err); end
    endtask

    task automatic test_dvsr();
        logic [31:0] rd;
        logic err;
        do_reset();
        apb_rd(A_DV, rd, err);
        total++; if (rd !== 32'd162) begin bad++; $display("FAIL dvsr_first_read got %h want a2", rd); end
        total++; if (last_ready !== 1'b1) begin bad++; $display("FAIL pready got %b want 1", last_ready); end
        apb_wr(A_DV, 32'h145, err);
        total++; if (last_dvsr !== 11'd162) begin bad++; $display("FAIL dvsr_during_access got %h want a2", last_dvsr); end
        total++; if (dvsr !== 11'h145) begin bad++; $display("FAIL dvsr_port got %h want 145", dvsr); end
        apb_rd(A_DV, rd, err);
        total++; if (rd !== 32'h145) begin bad++; $display("FAIL dvsr_readback got %h want 145", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic err;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_DV; pwdata = 32'h07B;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rd = prdata; err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        total++; if (rd !== 32'h07B || err !== 1'b0) begin bad++; $display("FAIL b2b_read got %h/%b want 7b/0", rd, err); end
    endtask

    task automatic test_tx_single();
        logic [31:0] rd;
        logic err;
        int n0;
        do_reset();
        tx_busy = 1'b0;
        n0 = launches.size();
        apb_wr(A_TX, 32'hFFFF_FFA5, err);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL tx_write_err got %b want 0", err); end
        repeat (4) @(posedge clk);
        total++; if (launches.size() - n0 != 1 || launches[$] !== 8'hA5) begin
            bad++; $display("FAIL tx_single_launch got n=%0d last=%h want n=1 last=a5", launches.size() - n0, launches[$]);
        end
        apb_rd(A_ST, rd, err);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL tx_wait_status got %h want 3", rd); end
        pulse_done();
        apb_rd(A_ST, rd, err);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL tx_done_status got %h want 2", rd); end
    endtask

    task automatic test_tx_busy();
        logic [31:0] rd;
        logic err;
        int n0;
        n0 = launches.size();
        tx_busy = 1'b1;
        apb_wr(A_TX, 32'hA5, err);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL busy_first_write got %b want 0", err); end
        apb_wr(A_TX, 32'h5A, err);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL busy_second_write got %b want 1", err); end
        repeat (6) @(posedge clk);
        total++; if (launches.size() != n0) begin bad++; $display("FAIL busy_no_launch got %0d want 0", launches.size() - n0); end
        apb_rd(A_ST, rd, err);
        total++; if (rd !== 32'h13) begin bad++; $display("FAIL busy_status got %h want 13", rd); end
        tx_busy = 1'b0;
        repeat (4) @(posedge clk);
        total++; if (launches.size() - n0 != 1 || launches[$] !== 8'hA5) begin
            bad++; $display("FAIL busy_launch got n=%0d last=%h want n=1 last=a5", launches.size() - n0, launches[$]);
        end
        tx_busy = 1'b1;
        pulse_done();
        tx_busy = 1'b0;
        repeat (4) @(posedge clk);
        total++; if (launches.size() - n0 != 1) begin bad++; $display("FAIL busy_dropped_data got n=%0d want 1", launches.size() - n0); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] rd;
        logic err;
        logic [7:0] vals[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_reset();
        foreach (vals[i]) rx_push(vals[i]);
        for (int i = 0; i < 4; i++) begin
            apb_rd(A_RX, rd, err);
            total++; if (rd !== {24'h0, vals[i]} || err !== 1'b0) begin
                bad++; $display("FAIL rx_read%0d got %h/%b want %h/0", i, rd, err, vals[i]);
            end
        end
        apb_rd(A_RX, rd, err);
        total++; if (rd !== 32'h0 || err !== 1'b1) begin bad++; $display("FAIL rx_read_empty got %h/%b want 0/1", rd, err); end
        apb_rd(A_ST, rd, err);
        total++; if (rd !== 32'hA) begin bad++; $display("FAIL overrun_status got %h want a", rd); end
        apb_wr(A_ST, 32'h8, err);
        apb_rd(A_ST, rd, err);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL overrun_clear got %h want 2", rd); end
    endtask

    task automatic test_full_pushpop();
        logic [31:0] rd;
        logic err;
        logic [7:0] q[$];
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            rx_push(b);
        end
        b = 8'($urandom);
        apb(1'b0, A_RX, 32'h0, 1'b1, b, rd, err);
        total++; if (rd !== {24'h0, q[0]} || err !== 1'b0) begin bad++; $display("FAIL pushpop_read got %h/%b want %h/0", rd, err, q[0]); end
        void'(q.pop_front());
        q.push_back(b);
        apb_rd(A_ST, rd, err);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL pushpop_status got %h want 4", rd); end
        for (int i = 0; i < 4; i++) begin
            apb_rd(A_RX, rd, err);
            total++; if (rd !== {24'h0, q[i]}) begin bad++; $display("FAIL pushpop_drain%0d got %h want %h", i, rd, q[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, w;
        logic err, exp_err, ovr;
        logic [7:0] q[$];
        logic [7:0] b;
        logic [10:0] exp_dvsr;
        do_reset();
        ovr = 1'b0;
        exp_dvsr = 11'd162;
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 6))
                0, 1: begin
                    b = 8'($urandom);
                    rx_push(b);
                    if (q.size() < 4) q.push_back(b);
                    else ovr = 1'b1;
                end
                2: begin
                    apb_rd(A_RX, rd, err);
                    exp = (q.size() > 0) ? {24'h0, q[0]} : 32'h0;
                    exp_err = (q.size() == 0);
                    if (q.size() > 0) void'(q.pop_front());
                    total++; if (rd !== exp || err !== exp_err) begin bad++; $display("FAIL rand_rx it=%0d got %h/%b want %h/%b", it, rd, err, exp, exp_err); end
                end
                3: begin
                    apb_rd(A_ST, rd, err);
                    exp = 32'h0;
                    if (q.size() == 0) exp = exp + 32'h2;
                    if (q.size() == 4) exp = exp + 32'h4;
                    if (ovr) exp = exp + 32'h8;
                    total++; if (rd !== exp) begin bad++; $display("FAIL rand_status it=%0d got %h want %h", it, rd, exp); end
                end
                4: begin
                    w = $urandom;
                    apb_wr(A_ST, w, err);
                    if (w[3]) ovr = 1'b0;
                end
                5: begin
                    b = 8'($urandom);
                    apb(1'b0, A_RX, 32'h0, 1'b1, b, rd, err);
                    exp = (q.size() > 0) ? {24'h0, q[0]} : 32'h0;
                    exp_err = (q.size() == 0);
                    if (q.size() > 0) void'(q.pop_front());
                    else if (q.size() >= 4) ovr = 1'b1;
                    q.push_back(b);
                    total++; if (rd !== exp || err !== exp_err) begin bad++; $display("FAIL rand_pushpop it=%0d got %h/%b want %h/%b", it, rd, err, exp, exp_err); end
                end
                default: begin
                    w = $urandom;
                    exp_dvsr = w[10:0];
                    apb_wr(A_DV, w, err);
                    apb_rd(A_DV, rd, err);
                    total++; if (rd !== {21'h0, exp_dvsr}) begin bad++; $display("FAIL rand_dvsr it=%0d got %h want %h", it, rd, exp_dvsr); end
                end
            endcase
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] rd;
        logic err;
        int n0;
        do_reset();
        tx_busy = 1'b0;
        n0 = launches.size();
        apb_wr(A_TX, 32'h3C, err);
        repeat (4) @(posedge clk);
        total++; if (launches.size() - n0 != 1 || launches[$] !== 8'h3C) begin
            bad++; $display("FAIL midtx_launch got n=%0d want 1", launches.size() - n0);
        end
        #1 rst = 1'b1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = A_RX;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (din !== 8'h00 || tx_start !== 1'b0) begin bad++; $display("FAIL midtx_reset_tx got din=%h start=%b want 00/0", din, tx_start); end
        total++; if (prdata !== 32'h0 || pslverr !== 1'b0) begin bad++; $display("FAIL midtx_reset_apb got %h/%b want 0/0", prdata, pslverr); end
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        n0 = launches.size();
        pulse_done();
        repeat (3) @(posedge clk);
        total++; if (launches.size() != n0) begin bad++; $display("FAIL midtx_after_done got %0d launches want 0", launches.size() - n0); end
        apb_rd(A_ST, rd, err);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL midtx_status got %h want 2", rd); end
    endtask

    initial begin
        rst = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'h0;
        tx_busy = 1'b0; tx_done_tick = 1'b0; rx_done_tick = 1'b0; dout = 8'h00;
        test_reset();
        test_dvsr();
        test_back_to_back();
        test_tx_single();
        test_tx_busy();
        test_rx_overrun();
        test_full_pushpop();
        test_random();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
